// File: rtl/seq1011_pkg.sv
// Shared constants for the 1011 frame transmitter: state encoding,
// preamble pattern and a small sizing helper.
package seq1011_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_PRE  = 2'd1;
  localparam state_t ST_DATA = 2'd2;
  localparam state_t ST_GAP  = 2'd3;

  localparam logic [3:0] PREAMBLE = 4'b1011;
  localparam int         PRE_LEN  = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq1011_tx_piso_shift.sv
// Parallel-load, serial-out shift register (MSB first, zero fill).
// Exposes the MSB it will hold after the current edge so the caller can register it.
module piso_shift
  import seq1011_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             sdo_d_o
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = sr_q << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sdo_d_o = sr_d[WIDTH-1];

endmodule

// File: rtl/seq1011_tx.sv
// Serial frame transmitter: preamble 1011, data word MSB-first, then GAP zeros.
// x is registered from next-state values so it changes only on the clock edge.
module seq1011_tx
  import seq1011_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             x,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(max3(WIDTH, GAP, PRE_LEN));

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          x_q, x_d;
  logic          load, shift, sdo_d;

  piso_shift #(.WIDTH(WIDTH)) u_piso (
    .clk     (clk),
    .rst_i   (reset),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (data_in),
    .sdo_d_o (sdo_d)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          state_d = ST_PRE;
          cnt_d   = CW'(PRE_LEN - 1);
          load    = 1'b1;
        end
      end
      ST_PRE: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = CW'(WIDTH - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        shift = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = CW'(GAP - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output bit for the upcoming cycle, decoded from the values about to be stored.
  always_comb begin
    case (state_d)
      ST_PRE:  x_d = PREAMBLE[cnt_d[1:0]];
      ST_DATA: x_d = sdo_d;
      default: x_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
    end
  end

  assign x     = x_q;
  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_GAP) && (cnt_q == CW'(GAP - 1));

endmodule

// File: tb/tb_seq1011_tx.sv
// Directed bench for seq1011_tx (WIDTH=8, GAP=2) with a 1011 Moore detector
// fed from x for loopback checks.
module tb_seq1011_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid;
  logic       ready, x, busy, done;

  int n_pass  = 0;
  int n_total = 0;
  int zc, zfirst;

  seq1011_tx #(.WIDTH(8), .GAP(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .valid   (valid),
    .ready   (ready),
    .x       (x),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Overlapping 1011 Moore detector; z is high in state 4.
  logic [2:0] det_q;
  logic       det_z;
  assign det_z = (det_q == 3'd4);

  always_ff @(posedge clk) begin
    if (reset) begin
      det_q <= 3'd0;
    end else begin
      case (det_q)
        3'd0:    det_q <= x ? 3'd1 : 3'd0;
        3'd1:    det_q <= x ? 3'd1 : 3'd2;
        3'd2:    det_q <= x ? 3'd3 : 3'd0;
        3'd3:    det_q <= x ? 3'd4 : 3'd2;
        3'd4:    det_q <= x ? 3'd1 : 3'd2;
        default: det_q <= 3'd0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Called while observing bit 1 of a frame; checks all 14 bit times and the
  // following IDLE cycle. inj >= 0 pulses valid with 8'h3C during that bit.
  task automatic run_frame(input string tag, input logic [13:0] bits, input int inj,
                           output int zc_o, output int zfirst_o);
    zc_o     = 0;
    zfirst_o = -1;
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("%s_bit%0d", tag, i + 1), {4'b0, x, done, ready, busy},
          {4'b0, bits[13-i], (i == 12), 1'b0, 1'b1});
      if (det_z) begin
        zc_o++;
        if (zfirst_o < 0) zfirst_o = i;
      end
      if (i == inj) begin
        valid   = 1'b1;
        data_in = 8'h3C;
      end
      step();
      if (i == inj) begin
        valid   = 1'b0;
        data_in = 8'h00;
      end
    end
    chk($sformatf("%s_idle", tag), {4'b0, x, done, ready, busy}, 8'b0000_0010);
    if (det_z) zc_o++;
  endtask

  initial begin
    reset   = 1'b1;
    valid   = 1'b0;
    data_in = 8'h00;
    step();
    step();
    chk("reset_state", {4'b0, x, ready, busy, done}, 8'b0000_0100);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("idle_%0d", i), {4'b0, x, ready, busy, done}, 8'b0000_0100);
    end

    // Single frame A5; data_in changed right after acceptance must not matter.
    valid   = 1'b1;
    data_in = 8'hA5;
    step();
    valid   = 1'b0;
    data_in = 8'h5A;
    run_frame("a5", 14'b1011_10100101_00, -1, zc, zfirst);

    // valid held high: 00 then FF, second frame starts 15 cycles after the first.
    valid   = 1'b1;
    data_in = 8'h00;
    step();
    data_in = 8'hFF;
    run_frame("b2b_00", 14'b1011_00000000_00, -1, zc, zfirst);
    step();
    valid   = 1'b0;
    data_in = 8'h00;
    run_frame("b2b_ff", 14'b1011_11111111_00, -1, zc, zfirst);

    // valid pulsed with 3C during DATA bit 3 is ignored and not queued.
    valid   = 1'b1;
    data_in = 8'h81;
    step();
    valid   = 1'b0;
    run_frame("busy_81", 14'b1011_10000001_00, 6, zc, zfirst);
    step();
    chk("busy_no_queue", {6'b0, busy, x}, 8'h00);

    // Reset during DATA bit 3 abandons the frame without done.
    valid   = 1'b1;
    data_in = 8'hA5;
    step();
    valid   = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("rst_pre_bit%0d", i + 1), {7'b0, x},
          {7'b0, (i < 4) ? ((i == 1) ? 1'b0 : 1'b1) : ((i == 4 || i == 6) ? 1'b1 : 1'b0)});
      if (i < 6) step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_frame", {4'b0, x, ready, busy, done}, 8'b0000_0100);
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("rst_after_%0d", i), {6'b0, busy, done}, 8'h00);
    end

    // Reset and valid together: reset wins.
    reset   = 1'b1;
    valid   = 1'b1;
    data_in = 8'hFF;
    step();
    reset = 1'b0;
    valid = 1'b0;
    chk("rst_valid_same", {5'b0, x, ready, busy}, 8'b0000_0010);
    step();
    chk("rst_valid_next", {5'b0, x, ready, busy}, 8'b0000_0010);

    // Loopback into the detector.
    valid   = 1'b1;
    data_in = 8'h00;
    step();
    valid   = 1'b0;
    run_frame("lb00", 14'b1011_00000000_00, -1, zc, zfirst);
    chk("lb00_zcount", 8'(zc), 8'd1);
    chk("lb00_zfirst", 8'(zfirst), 8'd4);

    valid   = 1'b1;
    data_in = 8'hB0;
    step();
    valid   = 1'b0;
    run_frame("lbb0", 14'b1011_10110000_00, -1, zc, zfirst);
    chk("lbb0_zcount", 8'(zc), 8'd2);
    chk("lbb0_zfirst", 8'(zfirst), 8'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
